// File: rtl/vadd_tb_pkg.sv
// Shared types and defaults for the vector-add response scoreboard.
package vadd_tb_pkg;

  localparam int unsigned LanesDef = 4;
  localparam int unsigned WidthDef = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE, TOUT} sb_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO; the head entry is presented from registered storage and advances on pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CntFull = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CntFull);
  assign o_empty = (r_count == '0);
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/vadd_scoreboard.sv
// In-order lane-by-lane checker of vector-add results against queued expected vectors.
module vadd_scoreboard
  import vadd_tb_pkg::*;
#(
  parameter int unsigned LANES   = LanesDef,
  parameter int unsigned WIDTH   = WidthDef,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned NUM_VEC = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_exp_valid,
  output logic                   o_exp_ready,
  input  logic [LANES*WIDTH-1:0] i_exp_data,
  input  logic                   i_act_valid,
  input  logic [LANES*WIDTH-1:0] i_act_data,
  output logic [7:0]             o_chk_count,
  output logic [7:0]             o_err_count,
  output logic [LANES-1:0]       o_err_lanes,
  output logic                   o_fail,
  output logic                   o_finish
);

  localparam int unsigned DW = LANES * WIDTH;
  localparam int unsigned IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IdleMax   = IW'(TIMEOUT);
  localparam logic [7:0]    ChkTarget = 8'(NUM_VEC);

  sb_state_t        r_state;
  sb_state_t        w_state_next;
  logic             r_rdy;
  logic [IW-1:0]    r_idle;
  logic [7:0]       r_chk_count;
  logic [7:0]       r_err_count;
  logic [LANES-1:0] r_err_lanes;
  logic             r_fail;
  logic             r_finish;

  logic [DW-1:0]    w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_underflow;
  logic             w_mismatch;
  logic [LANES-1:0] w_mask;

  // Ready stays low for the first cycle after reset is released.
  assign o_exp_ready = r_rdy && !w_full;
  assign w_push      = i_exp_valid && o_exp_ready;
  assign w_pop       = i_act_valid && !w_empty;
  assign w_underflow = i_act_valid && w_empty;
  assign w_mismatch  = w_pop && (|w_mask);

  sync_fifo #(
    .WIDTH(DW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_wdata(i_exp_data),
    .o_rdata(w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_mask[i] = (w_head[i*WIDTH +: WIDTH] != i_act_data[i*WIDTH +: WIDTH]);
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (w_push) w_state_next = RUN;
      RUN: begin
        if (r_chk_count >= ChkTarget && w_empty)   w_state_next = DONE;
        else if (!w_empty && r_idle == IdleMax)    w_state_next = TOUT;
      end
      DONE, TOUT: w_state_next = r_state;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_rdy       <= 1'b0;
      r_idle      <= '0;
      r_chk_count <= '0;
      r_err_count <= '0;
      r_err_lanes <= '0;
      r_fail      <= 1'b0;
      r_finish    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_rdy   <= 1'b1;
      if (i_act_valid || w_empty) r_idle <= '0;
      else if (r_idle != IdleMax) r_idle <= r_idle + IW'(1);
      if (w_pop) r_chk_count <= r_chk_count + 8'd1;
      if (w_mismatch || w_underflow) begin
        r_err_count <= sat_inc8(r_err_count);
        r_err_lanes <= w_underflow ? '1 : w_mask;
        r_fail      <= 1'b1;
      end
      if (w_state_next == TOUT) r_fail <= 1'b1;
      if (w_state_next == DONE || w_state_next == TOUT) r_finish <= 1'b1;
    end
  end

  assign o_chk_count = r_chk_count;
  assign o_err_count = r_err_count;
  assign o_err_lanes = r_err_lanes;
  assign o_fail      = r_fail;
  assign o_finish    = r_finish;

endmodule

// File: tb/tb_vadd_scoreboard.sv
// Directed bench for vadd_scoreboard: queue-based reference model plus literal pins.
module tb_vadd_scoreboard;

  localparam int unsigned LANES   = 4;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned NUM_VEC = 1;
  localparam int unsigned TIMEOUT = 16;

  logic        clk;
  logic        reset;
  logic        exp_valid;
  logic        exp_ready;
  logic [31:0] exp_data;
  logic        act_valid;
  logic [31:0] act_data;
  logic [7:0]  chk_count;
  logic [7:0]  err_count;
  logic [3:0]  err_lanes;
  logic        fail;
  logic        finish;

  int n_tests;
  int n_fail;

  vadd_scoreboard #(
    .LANES  (LANES),
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .NUM_VEC(NUM_VEC),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clock    (clk),
    .i_reset    (reset),
    .i_exp_valid(exp_valid),
    .o_exp_ready(exp_ready),
    .i_exp_data (exp_data),
    .i_act_valid(act_valid),
    .i_act_data (act_data),
    .o_chk_count(chk_count),
    .o_err_count(err_count),
    .o_err_lanes(err_lanes),
    .o_fail     (fail),
    .o_finish   (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  function automatic logic [31:0] vadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
    return r;
  endfunction

  // Reference model: expected vectors in a queue, results as plain counters/flags.
  logic [31:0] m_q[$];
  int          m_chk;
  int          m_err;
  logic [3:0]  m_lanes;
  bit          m_fail;
  bit          m_finish;
  bit          m_live;
  bit          m_started;
  bit          m_ended;
  bit          m_valid;
  int          m_idle;

  initial m_valid = 1'b0;

  always @(posedge clk) begin : model
    int          pre_size;
    bit          accept;
    logic [31:0] head;
    logic [3:0]  mask;
    if (reset) begin
      m_q.delete();
      m_chk = 0; m_err = 0; m_lanes = '0; m_fail = 0; m_finish = 0;
      m_live = 0; m_started = 0; m_ended = 0; m_idle = 0; m_valid = 1;
    end else begin
      pre_size = m_q.size();
      accept = exp_valid && m_live && (pre_size < DEPTH);
      if (m_started && !m_ended) begin
        if (m_chk >= NUM_VEC && pre_size == 0) begin
          m_ended = 1; m_finish = 1;
        end else if (pre_size > 0 && m_idle >= TIMEOUT) begin
          m_ended = 1; m_finish = 1; m_fail = 1;
        end
      end
      if (act_valid) begin
        mask = '0;
        if (pre_size == 0) begin
          mask = 4'hf;
        end else begin
          head = m_q.pop_front();
          m_chk++;
          for (int i = 0; i < 4; i++) mask[i] = (head[i*8 +: 8] != act_data[i*8 +: 8]);
        end
        if (mask != 0) begin
          m_err = (m_err < 255) ? m_err + 1 : 255;
          m_lanes = mask;
          m_fail = 1;
        end
      end
      if (act_valid || pre_size == 0) m_idle = 0;
      else if (m_idle < TIMEOUT) m_idle++;
      if (accept) begin
        m_q.push_back(exp_data);
        m_started = 1;
      end
      m_live = 1;
    end
  end

  always @(posedge clk) begin : compare
    #1;
    if (m_valid) begin
      chk("m_ready",  exp_ready, (m_live && m_q.size() < DEPTH) ? 1 : 0);
      chk("m_chk",    chk_count, m_chk & 255);
      chk("m_err",    err_count, m_err);
      chk("m_lanes",  err_lanes, m_lanes);
      chk("m_fail",   fail,      m_fail);
      chk("m_finish", finish,    m_finish);
    end
  end

  // Drive one cycle of inputs at a negedge, return at the next negedge.
  task automatic cyc(input bit ev, input logic [31:0] ed, input bit av, input logic [31:0] ad);
    exp_valid = ev; exp_data = ed; act_valid = av; act_data = ad;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; exp_valid = 1'b0; act_valid = 1'b0;
    @(negedge clk);
    chk("rst_chk",    chk_count, 0);
    chk("rst_err",    err_count, 0);
    chk("rst_lanes",  err_lanes, 0);
    chk("rst_fail",   fail,      0);
    chk("rst_finish", finish,    0);
    chk("rst_ready0", exp_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready1", exp_ready, 1);
  endtask

  logic [31:0] e1;
  logic [31:0] w3;

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b1; exp_valid = 1'b0; act_valid = 1'b0; exp_data = '0; act_data = '0;

    // 1: clean single vector, NUM_VEC=1 reached
    do_reset();
    e1 = vadd(pack4(2, 2, 8, 10), pack4(0, 4, 8, 1));
    cyc(1, e1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, pack4(2, 6, 16, 11));
    chk("t1_chk", chk_count, 1);
    chk("t1_err", err_count, 0);
    chk("t1_fail", fail, 0);
    chk("t1_fin_early", finish, 0);
    cyc(0, 0, 0, 0);
    chk("t1_finish", finish, 1);
    chk("t1_fail_end", fail, 0);

    // 2: lane 2 mismatch
    do_reset();
    cyc(1, e1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, pack4(2, 6, 15, 11));
    chk("t2_lanes", err_lanes, 4'b0100);
    chk("t2_err", err_count, 1);
    chk("t2_fail", fail, 1);
    chk("t2_chk", chk_count, 1);

    // 3: modulo-256 lane arithmetic
    do_reset();
    w3 = vadd(pack4(200, 1, 2, 3), pack4(100, 1, 2, 3));
    cyc(1, w3, 0, 0);
    cyc(1, w3, 0, 0);
    cyc(0, 0, 1, pack4(44, 2, 4, 6));
    chk("t3_pass_err", err_count, 0);
    chk("t3_pass_chk", chk_count, 1);
    cyc(0, 0, 1, pack4(45, 2, 4, 6));
    chk("t3_lanes", err_lanes, 4'b0001);
    chk("t3_err", err_count, 1);
    chk("t3_fail", fail, 1);
    cyc(0, 0, 0, 0);

    // 4: underflow, then same-cycle push+act on empty must not bypass
    do_reset();
    cyc(0, 0, 1, pack4(1, 2, 3, 4));
    chk("t4_fail", fail, 1);
    chk("t4_lanes", err_lanes, 4'hf);
    chk("t4_chk", chk_count, 0);
    chk("t4_err", err_count, 1);
    cyc(1, pack4(9, 9, 9, 9), 1, pack4(9, 9, 9, 9));
    chk("t4_nobypass_err", err_count, 2);
    chk("t4_nobypass_chk", chk_count, 0);
    cyc(0, 0, 1, pack4(9, 9, 9, 9));
    chk("t4_pop_chk", chk_count, 1);
    chk("t4_pop_err", err_count, 2);
    cyc(0, 0, 0, 0);

    // 5: timeout after 16 idle cycles with a pending entry
    do_reset();
    cyc(1, pack4(5, 5, 5, 5), 0, 0);
    repeat (16) cyc(0, 0, 0, 0);
    chk("t5_fin_early", finish, 0);
    chk("t5_fail_early", fail, 0);
    cyc(0, 0, 0, 0);
    chk("t5_finish", finish, 1);
    chk("t5_fail", fail, 1);
    chk("t5_chk", chk_count, 0);

    // 6: fill, push+pop while full, then reset mid-run
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, pack4(i, i + 1, i + 2, i + 3), 0, 0);
    chk("t6_full_ready", exp_ready, 0);
    cyc(1, pack4(99, 99, 99, 99), 1, pack4(0, 1, 2, 3));
    chk("t6_pop_chk", chk_count, 1);
    chk("t6_pop_err", err_count, 0);
    chk("t6_ready", exp_ready, 1);
    cyc(0, 0, 1, pack4(1, 2, 3, 4));
    cyc(0, 0, 1, pack4(2, 3, 4, 5));
    chk("t6_mid_chk", chk_count, 3);
    chk("t6_mid_err", err_count, 0);
    cyc(0, 0, 0, 0);
    do_reset();
    cyc(0, 0, 1, pack4(3, 4, 5, 6));
    chk("t6_flush_lanes", err_lanes, 4'hf);
    chk("t6_flush_err", err_count, 1);
    chk("t6_flush_chk", chk_count, 0);
    cyc(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
